// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port initiator: merges ALU results and queued loads into one write per cycle.
// Optional macro WB_FWD_EN enables CHK_DATA forwarding of the youngest pending write.
module regfile_wb_ctrl #(
    parameter int unsigned LQ_DEPTH = 4,
    parameter int unsigned XLEN     = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ALU_VALID,
    input  logic [4:0]                    ALU_RD,
    input  logic [XLEN-1:0]               ALU_DATA,
    input  logic                          LD_VALID,
    output logic                          LD_READY,
    input  logic [4:0]                    LD_RD,
    input  logic [XLEN-1:0]               LD_DATA,
    output logic [4:0]                    A3,
    output logic [XLEN-1:0]               WD3,
    output logic                          EN,
    output logic [$clog2(LQ_DEPTH):0]     LQ_COUNT,
    input  logic [4:0]                    CHK_ADDR,
    output logic                          CHK_HIT,
    output logic [XLEN-1:0]               CHK_DATA
);
    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]      r_lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] r_lq_data [LQ_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_a3;
    logic [XLEN-1:0]  r_wd3;
    logic             r_en;

    logic w_full;
    logic w_empty;
    logic w_alu_take;
    logic w_push;
    logic w_pop;
    logic w_chk_hit;

    assign w_full     = (r_count == CNT_W'(LQ_DEPTH));
    assign w_empty    = (r_count == '0);
    assign LD_READY   = !RST && !w_full;
    assign w_alu_take = ALU_VALID && (ALU_RD != 5'd0);
    // rd==0 loads complete the handshake but never occupy a slot.
    assign w_push     = LD_VALID && LD_READY && (LD_RD != 5'd0);
    assign w_pop      = !w_alu_take && !w_empty;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_lq_rd[r_wr_ptr]   <= LD_RD;
            r_lq_data[r_wr_ptr] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_en     <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_alu_take) begin
                r_en  <= 1'b1;
                r_a3  <= ALU_RD;
                r_wd3 <= ALU_DATA;
            end else if (w_pop) begin
                r_en  <= 1'b1;
                r_a3  <= r_lq_rd[r_rd_ptr];
                r_wd3 <= r_lq_data[r_rd_ptr];
            end else begin
                r_en  <= 1'b0;
            end
        end
    end

`ifdef WB_FWD_EN
    logic [XLEN-1:0] w_chk_data;
`endif

    // Output stage first, then queue oldest to youngest, so the youngest match wins.
    always_comb begin
        w_chk_hit = 1'b0;
`ifdef WB_FWD_EN
        w_chk_data = '0;
`endif
        if (CHK_ADDR != 5'd0) begin
            if (r_en && (r_a3 == CHK_ADDR)) begin
                w_chk_hit = 1'b1;
`ifdef WB_FWD_EN
                w_chk_data = r_wd3;
`endif
            end
            for (int k = 0; k < int'(LQ_DEPTH); k++) begin
                if ((k < int'(r_count)) && (r_lq_rd[r_rd_ptr + PTR_W'(k)] == CHK_ADDR)) begin
                    w_chk_hit = 1'b1;
`ifdef WB_FWD_EN
                    w_chk_data = r_lq_data[r_rd_ptr + PTR_W'(k)];
`endif
                end
            end
        end
    end

`ifdef WB_FWD_EN
    assign CHK_DATA = w_chk_data;
`else
    assign CHK_DATA = '0;
`endif

    assign CHK_HIT  = w_chk_hit;
    assign A3       = r_a3;
    assign WD3      = r_wd3;
    assign EN       = r_en;
    assign LQ_COUNT = r_count;
endmodule
